// File: rtl/pipe_issue_arbiter.sv
// Round-robin issue arbiter sharing one fixed-latency pipelined unit among n_req requesters.
// Define PIPE_ISSUE_ARBITER_CHECK_EN to build the sticky pipe-timing error check.
module pipe_issue_arbiter #(
  parameter int n_req        = 4,
  parameter int width        = 8,
  parameter int latency      = 3,
  parameter int max_inflight = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [n_req-1:0]         req_vld,
  input  logic [n_req*width-1:0]   req_data,
  output logic [n_req-1:0]         req_rdy,
  output logic                     pipe_in_vld,
  output logic [width-1:0]         pipe_in_data,
  input  logic                     pipe_out_vld,
  input  logic [width-1:0]         pipe_out_data,
  output logic [n_req-1:0]         res_vld,
  output logic [width-1:0]         res_data,
  output logic                     err
);

  localparam int id_w  = $clog2(n_req);
  localparam int cnt_w = $clog2(max_inflight + 1);
  localparam int depth = latency + 1;

  logic [id_w-1:0]  rr_ptr;
  logic [cnt_w-1:0] inflight [n_req];
  logic [n_req-1:0] eligible;
  logic             grant_any;
  logic [id_w-1:0]  grant_id;
  logic [n_req-1:0] grant_oh;
  logic             accept;

  logic [depth-1:0] tag_vld;
  logic [id_w-1:0]  tag_id [depth];
  logic             exit_vld;
  logic [id_w-1:0]  exit_id;
  logic [n_req-1:0] exit_oh;

  always_comb begin
    for (int i = 0; i < n_req; i++)
      eligible[i] = req_vld[i] && (inflight[i] < cnt_w'(max_inflight));
  end

  // Scan from the far end toward the pointer so the nearest eligible requester wins.
  always_comb begin
    logic [id_w:0] sum;
    // NOTE: every variable gets a default before any conditional write, otherwise a latch is inferred.
    grant_any = 1'b0;
    grant_id  = '0;
    sum       = '0;
    for (int k = n_req - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (id_w+1)'(k);
      if (sum >= (id_w+1)'(n_req))
        sum = sum - (id_w+1)'(n_req);
      if (eligible[id_w'(sum)]) begin
        grant_any = 1'b1;
        grant_id  = id_w'(sum);
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    if (grant_any && !rst)
      grant_oh[grant_id] = 1'b1;
  end

  assign req_rdy = grant_oh;
  assign accept  = |(req_vld & grant_oh);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      pipe_in_vld <= 1'b0;
    end else begin
      pipe_in_vld <= accept;
      if (accept)
        rr_ptr <= (grant_id == id_w'(n_req - 1)) ? '0 : grant_id + id_w'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      pipe_in_data <= req_data[int'(grant_id)*width +: width];
  end

  // Tag stage depth-1 lines up with pipe_out_vld for the op accepted latency+1 cycles earlier.
  always_ff @(posedge clk) begin
    if (rst)
      tag_vld <= '0;
    else
      tag_vld <= {tag_vld[depth-2:0], accept};
  end

  // NOTE: id storage is left unreset; only the valid bits need a known value after reset.
  always_ff @(posedge clk) begin
    tag_id[0] <= grant_id;
    for (int k = 1; k < depth; k++)
      tag_id[k] <= tag_id[k-1];
  end

  assign exit_vld = tag_vld[depth-1];
  assign exit_id  = tag_id[depth-1];

  always_comb begin
    exit_oh = '0;
    if (exit_vld)
      exit_oh[exit_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < n_req; i++)
        inflight[i] <= '0;
    end else begin
      for (int i = 0; i < n_req; i++) begin
        if (grant_oh[i] && req_vld[i] && !exit_oh[i])
          inflight[i] <= inflight[i] + cnt_w'(1);
        else if (exit_oh[i] && !(grant_oh[i] && req_vld[i]))
          inflight[i] <= inflight[i] - cnt_w'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      res_vld <= '0;
    else
      res_vld <= exit_oh;
  end

  always_ff @(posedge clk) begin
    if (exit_vld)
      res_data <= pipe_out_data;
  end

`ifdef PIPE_ISSUE_ARBITER_CHECK_EN
  localparam int mask_w = $clog2(depth + 1);
  logic [mask_w-1:0] mask_cnt;

  // Stale pipe outputs from before reset drain out while mask_cnt is nonzero.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_cnt <= mask_w'(depth);
      err      <= 1'b0;
    end else begin
      if (mask_cnt != '0)
        mask_cnt <= mask_cnt - mask_w'(1);
      if (mask_cnt == '0 && pipe_out_vld != exit_vld)
        err <= 1'b1;
    end
  end
`else
  logic unused_pipe_out_vld;
  assign unused_pipe_out_vld = pipe_out_vld;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_issue_arbiter.sv
// Directed bench for pipe_issue_arbiter with a 3-cycle data+1 stub pipe; err expectations follow PIPE_ISSUE_ARBITER_CHECK_EN.
module tb_pipe_issue_arbiter;

  localparam int n_req        = 4;
  localparam int width        = 8;
  localparam int latency      = 3;
  localparam int max_inflight = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [n_req-1:0]       req_vld;
  logic [n_req*width-1:0] req_data;
  logic [n_req-1:0]       req_rdy;
  logic                   pipe_in_vld;
  logic [width-1:0]       pipe_in_data;
  logic                   pipe_out_vld;
  logic [width-1:0]       pipe_out_data;
  logic [n_req-1:0]       res_vld;
  logic [width-1:0]       res_data;
  logic                   err;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_issue_arbiter #(
    .n_req(n_req), .width(width), .latency(latency), .max_inflight(max_inflight)
  ) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_data(req_data), .req_rdy(req_rdy),
    .pipe_in_vld(pipe_in_vld), .pipe_in_data(pipe_in_data),
    .pipe_out_vld(pipe_out_vld), .pipe_out_data(pipe_out_data),
    .res_vld(res_vld), .res_data(res_data), .err(err)
  );

  always #5 clk = ~clk;

  // Stub pipe: 3-cycle delay computing data+1; kill_in drops the valid of the op entering it.
  logic [2:0]       s_vld = '0;
  logic [width-1:0] s_data [3];
  logic             kill_in = 1'b0;

  always @(posedge clk) begin
    s_vld     <= {s_vld[1:0], pipe_in_vld & ~kill_in};
    s_data[0] <= pipe_in_data + 8'd1;
    s_data[1] <= s_data[0];
    s_data[2] <= s_data[1];
  end

  assign pipe_out_vld  = s_vld[2];
  assign pipe_out_data = s_data[2];

`ifdef PIPE_ISSUE_ARBITER_CHECK_EN
  localparam bit check_en = 1'b1;
`else
  localparam bit check_en = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    req_vld = '0;
    kill_in = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    req_vld  = 4'b1111;
    req_data = '0;
    #1;
    n_tests++;
    if (req_rdy !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_rdy: got %b expected %b", req_rdy, 4'b0000);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (pipe_in_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pipe_in_vld: got %b expected 0", pipe_in_vld);
    end
    n_tests++;
    if (res_vld !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_res_vld: got %b expected 0000", res_vld);
    end
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err: got %b expected 0", err);
    end
    tick();
    rst     = 1'b0;
    req_vld = '0;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    req_vld        = 4'b0010;
    req_data       = '0;
    req_data[15:8] = 8'h5A;
    @(negedge clk);
    n_tests++;
    if (req_rdy !== 4'b0010) begin
      n_fail++;
      $display("FAIL single_rdy c0: got %b expected 0010", req_rdy);
    end
    tick();
    req_vld = '0;
    @(negedge clk);
    n_tests++;
    if (pipe_in_vld !== 1'b1 || pipe_in_data !== 8'h5A) begin
      n_fail++;
      $display("FAIL single_issue c1: got vld=%b data=%h expected vld=1 data=5a", pipe_in_vld, pipe_in_data);
    end
    for (int c = 2; c <= 6; c++) begin
      tick();
      @(negedge clk);
      n_tests++;
      if (res_vld !== ((c == 5) ? 4'b0010 : 4'b0000)) begin
        n_fail++;
        $display("FAIL single_res_vld c%0d: got %b expected %b", c, res_vld, (c == 5) ? 4'b0010 : 4'b0000);
      end
      if (c == 5) begin
        n_tests++;
        if (res_data !== 8'h5B || err !== 1'b0) begin
          n_fail++;
          $display("FAIL single_res_data c5: got data=%h err=%b expected data=5b err=0", res_data, err);
        end
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int pulses;
    logic [n_req-1:0] exp_rdy;
    logic [n_req-1:0] exp_res;
    logic [width-1:0] exp_data;
    pulses = 0;
    do_reset();
    for (int c = 0; c < 18; c++) begin
      req_vld = (c < 12) ? 4'b1111 : 4'b0000;
      for (int i = 0; i < n_req; i++)
        req_data[i*width +: width] = 8'(c*16 + i);
      @(negedge clk);
      exp_rdy = (c < 12) ? 4'(1 << (c % 4)) : 4'b0000;
      n_tests++;
      if (req_rdy !== exp_rdy) begin
        n_fail++;
        $display("FAIL b2b_rdy c%0d: got %b expected %b", c, req_rdy, exp_rdy);
      end
      if (c >= 1 && c <= 12) begin
        exp_data = 8'((c-1)*16 + (c-1) % 4);
        n_tests++;
        if (pipe_in_vld !== 1'b1 || pipe_in_data !== exp_data) begin
          n_fail++;
          $display("FAIL b2b_issue c%0d: got vld=%b data=%h expected vld=1 data=%h", c, pipe_in_vld, pipe_in_data, exp_data);
        end
      end
      exp_res = (c >= 5 && c <= 16) ? 4'(1 << ((c-5) % 4)) : 4'b0000;
      n_tests++;
      if (res_vld !== exp_res) begin
        n_fail++;
        $display("FAIL b2b_res_vld c%0d: got %b expected %b", c, res_vld, exp_res);
      end
      if (exp_res != 4'b0000) begin
        exp_data = 8'((c-5)*16 + (c-5) % 4 + 1);
        n_tests++;
        if (res_data !== exp_data) begin
          n_fail++;
          $display("FAIL b2b_res_data c%0d: got %h expected %h", c, res_data, exp_data);
        end
      end
      if (res_vld != 4'b0000)
        pulses++;
      tick();
    end
    n_tests++;
    if (pulses !== 12) begin
      n_fail++;
      $display("FAIL b2b_pulse_count: got %0d expected 12", pulses);
    end
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_err: got %b expected 0", err);
    end
  endtask

  task automatic test_inflight_limit();
    logic [7:0] exp_rdy2;
    logic [7:0] exp_res2;
    logic [n_req-1:0] want;
    exp_rdy2 = 8'b0110_0011;
    exp_res2 = 8'b0110_0000;
    do_reset();
    req_data = '0;
    for (int c = 0; c < 8; c++) begin
      req_vld = 4'b0100;
      req_data[23:16] = 8'(8'h40 + c);
      @(negedge clk);
      want = {1'b0, exp_rdy2[c], 2'b00};
      n_tests++;
      if (req_rdy !== want) begin
        n_fail++;
        $display("FAIL limit_rdy c%0d: got %b expected %b", c, req_rdy, want);
      end
      want = {1'b0, exp_res2[c], 2'b00};
      n_tests++;
      if (res_vld !== want) begin
        n_fail++;
        $display("FAIL limit_res_vld c%0d: got %b expected %b", c, res_vld, want);
      end
      tick();
    end
    req_vld = '0;
    for (int c = 0; c < 8; c++)
      tick();
  endtask

  task automatic test_dropped_result();
    logic exp_err;
    logic [n_req-1:0] exp_res;
    logic [width-1:0] exp_data;
    do_reset();
    req_data        = '0;
    req_data[7:0]   = 8'h11;
    req_data[23:16] = 8'h44;
    req_data[31:24] = 8'h30;
    for (int c = 0; c < 23; c++) begin
      req_vld = (c == 0) ? 4'b0001 : (c == 10) ? 4'b1000 : (c == 16) ? 4'b0100 : 4'b0000;
      kill_in = (c == 11);
      @(negedge clk);
      exp_err = check_en && (c >= 15);
      n_tests++;
      if (err !== exp_err) begin
        n_fail++;
        $display("FAIL drop_err c%0d: got %b expected %b", c, err, exp_err);
      end
      exp_res  = (c == 5) ? 4'b0001 : (c == 15) ? 4'b1000 : (c == 21) ? 4'b0100 : 4'b0000;
      exp_data = (c == 5) ? 8'h12 : (c == 15) ? 8'h31 : 8'h45;
      n_tests++;
      if (res_vld !== exp_res) begin
        n_fail++;
        $display("FAIL drop_res_vld c%0d: got %b expected %b", c, res_vld, exp_res);
      end
      if (exp_res != 4'b0000) begin
        n_tests++;
        if (res_data !== exp_data) begin
          n_fail++;
          $display("FAIL drop_res_data c%0d: got %h expected %h", c, res_data, exp_data);
        end
      end
      tick();
    end
    kill_in = 1'b0;
    req_vld = '0;
  endtask

  task automatic test_reset_mid_flight();
    logic [n_req-1:0] exp_res;
    do_reset();
    for (int i = 0; i < n_req; i++)
      req_data[i*width +: width] = 8'(8'hA0 + i);
    for (int c = 0; c < 3; c++) begin
      req_vld = 4'b0111;
      @(negedge clk);
      if (c == 0) begin
        n_tests++;
        if (err !== 1'b0) begin
          n_fail++;
          $display("FAIL midrst_err_cleared: got %b expected 0", err);
        end
      end
      n_tests++;
      if (req_rdy !== 4'(1 << c)) begin
        n_fail++;
        $display("FAIL midrst_rdy c%0d: got %b expected %b", c, req_rdy, 4'(1 << c));
      end
      tick();
    end
    rst     = 1'b1;
    req_vld = 4'b1111;
    #1;
    n_tests++;
    if (req_rdy !== 4'b0000) begin
      n_fail++;
      $display("FAIL midrst_rdy_in_rst: got %b expected 0000", req_rdy);
    end
    tick();
    rst             = 1'b0;
    req_data[15:8]  = 8'h77;
    for (int c = 0; c < 10; c++) begin
      req_vld = (c == 4) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      if (c == 4) begin
        n_tests++;
        if (req_rdy !== 4'b0010) begin
          n_fail++;
          $display("FAIL midrst_new_rdy: got %b expected 0010", req_rdy);
        end
      end
      exp_res = (c == 9) ? 4'b0010 : 4'b0000;
      n_tests++;
      if (res_vld !== exp_res || err !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_res c%0d: got vld=%b err=%b expected vld=%b err=0", c, res_vld, err, exp_res);
      end
      if (c == 9) begin
        n_tests++;
        if (res_data !== 8'h78) begin
          n_fail++;
          $display("FAIL midrst_res_data: got %h expected 78", res_data);
        end
      end
      tick();
    end
    req_vld = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    req_vld  = '0;
    req_data = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_inflight_limit();
    test_dropped_result();
    test_reset_mid_flight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_issue_arbiter.md
Name: pipe_issue_arbiter

Overview:
- Round-robin arbiter that shares one fixed-latency pipelined arithmetic unit (e.g. the sqrt-formula pipe) among n_req requesters.
- Accepts one request per cycle and issues it to the pipe.
- Carries the requester ID alongside the pipe in an internal valid/tag shift register, then routes each result back to its originator.
- Limits outstanding operations per requester and optionally checks that the pipe's output valid matches the expected timing.

Parameters:
- n_req, 4: number of requesters (2..8)
- width, 8: data width of arguments and results
- latency, 3: pipe latency in cycles from pipe_in_vld to pipe_out_vld (>=1)
- max_inflight, 2: maximum outstanding operations per requester (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_vld  in  n_req  per-requester request valid
- req_data  in  n_req*width  packed arguments; requester i uses bits [i*width +: width]
- req_rdy  out  n_req  one-hot grant, combinational; accept = req_vld[i] & req_rdy[i]
- pipe_in_vld  out  1  registered issue valid to the pipe
- pipe_in_data  out  width  registered argument to the pipe
- pipe_out_vld  in  1  result valid from the pipe
- pipe_out_data  in  width  result from the pipe
- res_vld  out  n_req  registered one-hot result strobe
- res_data  out  width  registered result, meaningful only when |res_vld
- err  out  1  sticky protocol error

Behaviour:
- Reset values:
  - pipe_in_vld=0, res_vld=0, err=0.
  - Round-robin pointer=0, all in-flight counters=0, tag pipeline valids=0.
  - pipe_in_data and res_data are don't-care.
- Eligibility: requester i is eligible when req_vld[i]=1 and inflight[i] < max_inflight.
- Grant:
  - Search starts at the pointer and wraps modulo n_req; the first eligible requester is granted.
  - At most one req_rdy bit is high. req_rdy=0 while rst=1.
  - req_rdy depends only on the registered pointer/counters and req_vld, never on req_data.
- On accept of requester g:
  - The pointer becomes (g+1) mod n_req.
  - Next cycle pipe_in_vld=1 and pipe_in_data=req_data[g].
  - With no accept, the pointer holds and the next cycle has pipe_in_vld=0.
- Tag pipeline:
  - Entries carry {valid, id}, depth latency+1; valid bits are reset, id bits are not.
  - Entry written on accept; the exiting entry is aligned with pipe_out_vld, i.e. the cycle latency+1 after accept.
- Return:
  - When the exiting tag is valid, next cycle res_vld[id]=1 and res_data=pipe_out_data.
  - res_vld is driven by the tag, not by pipe_out_vld.
  - Accept-to-result latency is latency+2 cycles.
- Counters:
  - inflight[i] increments on accept by i and decrements on tag exit with id i.
  - Both in the same cycle leaves it unchanged.
  - Width $clog2(max_inflight+1); the counter never over- or underflows by construction.
- Back-to-back: a new accept is allowed every cycle and the pipe is fully pipelined.
- Reset mid-operation:
  - All outstanding tags are discarded and no res_vld appears for them.
  - Counters are cleared.
- Post-reset mask:
  - A counter blocks error checking for latency+1 cycles after rst deasserts, so stale pipe outputs are ignored.
  - Issue is allowed during the mask window.

Optional Feature:
- Macro: PIPE_ISSUE_ARBITER_CHECK_EN.
- Defined:
  - Outside the mask window, any cycle where pipe_out_vld differs from the exiting tag valid sets err=1 on the next cycle.
  - err stays 1 until rst.
  - Routing is unaffected.
- Undefined: err is tied 0, pipe_out_vld is ignored, and the mask counter is not built.

Test Plan:
(All scenarios: n_req=4, width=8, latency=3, max_inflight=2. Stub pipe = 3-cycle delay computing data+1.)
- Single request: cycle 0 after reset, req_vld=4'b0010, req_data[1]=8'h5A -> req_rdy=4'b0010 in cycle 0; pipe_in_vld=1 with data 8'h5A in cycle 1; pipe_out_vld in cycle 4; res_vld=4'b0010 with res_data=8'h5B in cycle 5; err=0.
- Full contention: req_vld=4'b1111 held 12 cycles with distinct data -> grant order 0,1,2,3,0,1,...; each requester is granted only while inflight < 2; every result returns to its originator with data+1; the number of res_vld pulses equals the number of accepts.
- In-flight limit: requester 2 alone holds req_vld -> accepts in cycles 0 and 1; req_rdy[2]=0 in cycles 2..4; res_vld[2] in cycle 5; req_rdy[2]=1 again from cycle 5.
- Dropped result (macro defined): stub suppresses pipe_out_vld for the op accepted in cycle 10 -> err=1 in cycle 15; err stays 1 through further traffic until rst.
- Reset mid-flight (macro defined): 3 ops outstanding, rst pulsed for 1 cycle -> no res_vld afterwards; stale stub outputs within 4 cycles after reset leave err=0; a new request then completes normally.
- Macro undefined: repeat the dropped-result case -> err stays 0 and res_vld still pulses for the dropped op.
